// File: rtl/dsp_pkg.sv
// Shared widths, OPMODE bit positions and mux encodings for the dsp multiply/accumulate slice.
package dsp_pkg;

    localparam int A_W = 18;
    localparam int M_W = 36;
    localparam int P_W = 48;

    localparam int OP_X_LSB       = 0;
    localparam int OP_Z_LSB       = 2;
    localparam int OP_PREADD_SEL  = 4;
    localparam int OP_CARRYIN     = 5;
    localparam int OP_PREADD_SUB  = 6;
    localparam int OP_POSTADD_SUB = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } xsel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } zsel_e;

    localparam string CARRYINSEL_OPMODE5 = "OPMODE5";
    localparam string CARRYINSEL_CARRYIN = "CARRYIN";
    localparam string B_INPUT_DIRECT     = "DIRECT";
    localparam string B_INPUT_CASCADE    = "CASCADE";

endpackage

// File: rtl/dsp_pipe_reg.sv
// One optional pipeline stage: a clear/enable flop when EN_REG is set, otherwise a plain wire.
module dsp_pipe_reg #(
    parameter int WIDTH  = 18,
    parameter bit EN_REG = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (EN_REG) begin : g_reg
            logic [WIDTH-1:0] q_q;

            // Synchronous clear wins over the clock enable.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    q_q <= '0;
                end else if (rst) begin
                    q_q <= '0;
                end else if (ce) begin
                    q_q <= d;
                end
            end

            assign q = q_q;
        end else begin : g_wire
            logic unused_ok;
            assign unused_ok = ^{CLK, RST_N, rst, ce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/dsp.sv
// 18x18 multiply / 48-bit accumulate slice with pre-adder, X/Z post-adder muxes and cascade ports.
// Define DSP_SIGNED_MULT_EN for a two's-complement multiplier with sign-extended M on the X mux.
module dsp
    import dsp_pkg::*;
#(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = CARRYINSEL_OPMODE5,
    parameter string B_INPUT     = B_INPUT_DIRECT
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [A_W-1:0] A,
    input  logic [A_W-1:0] B,
    input  logic [A_W-1:0] BCIN,
    input  logic [A_W-1:0] D,
    input  logic [P_W-1:0] C,
    input  logic [P_W-1:0] PCIN,
    input  logic [7:0]     OPMODE,
    input  logic           CARRYIN,
    input  logic           RSTA,
    input  logic           RSTB,
    input  logic           RSTC,
    input  logic           RSTD,
    input  logic           RSTM,
    input  logic           RSTP,
    input  logic           RSTCARRYIN,
    input  logic           RSTOPMODE,
    input  logic           CEA,
    input  logic           CEB,
    input  logic           CEC,
    input  logic           CED,
    input  logic           CEM,
    input  logic           CEP,
    input  logic           CECARRYIN,
    input  logic           CEOPMODE,
    output logic [A_W-1:0] BCOUT,
    output logic [M_W-1:0] M,
    output logic [P_W-1:0] P,
    output logic [P_W-1:0] PCOUT,
    output logic           CARRYOUT,
    output logic           CARRYOUTF
);

    localparam bit USE_BCIN         = (B_INPUT == B_INPUT_CASCADE);
    localparam bit USE_CARRYIN_PORT = (CARRYINSEL == CARRYINSEL_CARRYIN);

    logic [A_W-1:0] a0_q, a1_q, b0_q, b1_q, d_q, b_src, pre_sum, b1_d;
    logic [P_W-1:0] c_q, p_q, x_mux, z_mux, p_d;
    logic [M_W-1:0] m_q, m_d;
    logic [7:0]     op_q;
    logic           cin_d, cyi_q, co_q, co_d;
    logic [P_W:0]   post_sum;

    assign b_src = USE_BCIN ? BCIN : B;
    assign cin_d = USE_CARRYIN_PORT ? CARRYIN : op_q[OP_CARRYIN];

    dsp_pipe_reg #(.WIDTH(A_W), .EN_REG(A0REG != 0)) u_a0 (
        .CLK(CLK), .RST_N(RST_N), .rst(RSTA), .ce(CEA), .d(A), .q(a0_q));
    dsp_pipe_reg #(.WIDTH(A_W), .EN_REG(A1REG != 0)) u_a1 (
        .CLK(CLK), .RST_N(RST_N), .rst(RSTA), .ce(CEA), .d(a0_q), .q(a1_q));
    dsp_pipe_reg #(.WIDTH(A_W), .EN_REG(B0REG != 0)) u_b0 (
        .CLK(CLK), .RST_N(RST_N), .rst(RSTB), .ce(CEB), .d(b_src), .q(b0_q));
    dsp_pipe_reg #(.WIDTH(A_W), .EN_REG(B1REG != 0)) u_b1 (
        .CLK(CLK), .RST_N(RST_N), .rst(RSTB), .ce(CEB), .d(b1_d), .q(b1_q));
    dsp_pipe_reg #(.WIDTH(A_W), .EN_REG(DREG != 0)) u_d (
        .CLK(CLK), .RST_N(RST_N), .rst(RSTD), .ce(CED), .d(D), .q(d_q));
    dsp_pipe_reg #(.WIDTH(P_W), .EN_REG(CREG != 0)) u_c (
        .CLK(CLK), .RST_N(RST_N), .rst(RSTC), .ce(CEC), .d(C), .q(c_q));
    dsp_pipe_reg #(.WIDTH(8), .EN_REG(OPMODEREG != 0)) u_op (
        .CLK(CLK), .RST_N(RST_N), .rst(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(op_q));
    dsp_pipe_reg #(.WIDTH(M_W), .EN_REG(MREG != 0)) u_m (
        .CLK(CLK), .RST_N(RST_N), .rst(RSTM), .ce(CEM), .d(m_d), .q(m_q));
    dsp_pipe_reg #(.WIDTH(1), .EN_REG(CARRYINREG != 0)) u_cyi (
        .CLK(CLK), .RST_N(RST_N), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(cin_d), .q(cyi_q));
    dsp_pipe_reg #(.WIDTH(P_W), .EN_REG(PREG != 0)) u_p (
        .CLK(CLK), .RST_N(RST_N), .rst(RSTP), .ce(CEP), .d(p_d), .q(p_q));
    dsp_pipe_reg #(.WIDTH(1), .EN_REG(CARRYOUTREG != 0)) u_co (
        .CLK(CLK), .RST_N(RST_N), .rst(RSTP), .ce(CEP), .d(co_d), .q(co_q));

    always_comb begin
        pre_sum = op_q[OP_PREADD_SUB] ? (d_q - b0_q) : (d_q + b0_q);
        b1_d    = op_q[OP_PREADD_SEL] ? pre_sum : b0_q;
    end

`ifdef DSP_SIGNED_MULT_EN
    logic signed [M_W-1:0] a1_sx, b1_sx;
    always_comb begin
        a1_sx = M_W'(signed'(a1_q));
        b1_sx = M_W'(signed'(b1_q));
        m_d   = a1_sx * b1_sx;
    end
`else
    assign m_d = {{(M_W-A_W){1'b0}}, a1_q} * {{(M_W-A_W){1'b0}}, b1_q};
`endif

    always_comb begin
        x_mux = '0;
        case (xsel_e'(op_q[OP_X_LSB +: 2]))
`ifdef DSP_SIGNED_MULT_EN
            X_M:     x_mux = {{(P_W-M_W){m_q[M_W-1]}}, m_q};
`else
            X_M:     x_mux = {{(P_W-M_W){1'b0}}, m_q};
`endif
            X_P:     x_mux = p_q;
            X_DAB:   x_mux = {d_q[11:0], a1_q, b1_q};
            default: x_mux = '0;
        endcase

        z_mux = '0;
        case (zsel_e'(op_q[OP_Z_LSB +: 2]))
            Z_PCIN:  z_mux = PCIN;
            Z_P:     z_mux = p_q;
            Z_C:     z_mux = c_q;
            default: z_mux = '0;
        endcase

        // Bit 48 is the carry when adding and the borrow when subtracting.
        if (op_q[OP_POSTADD_SUB]) begin
            post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cyi_q});
        end else begin
            post_sum = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cyi_q};
        end
        p_d  = post_sum[P_W-1:0];
        co_d = post_sum[P_W];
    end

    assign BCOUT     = b1_q;
    assign M         = m_q;
    assign P         = p_q;
    assign PCOUT     = p_q;
    assign CARRYOUT  = co_q;
    assign CARRYOUTF = co_q;

endmodule

// File: tb/tb_dsp.sv
// Directed-vector bench for the dsp slice in its default pipeline configuration.
module tb_dsp;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [17:0] A, B, BCIN, D;
    logic [47:0] C, PCIN;
    logic [7:0]  OPMODE;
    logic        CARRYIN;
    logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
    logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
    logic [17:0] BCOUT;
    logic [35:0] M;
    logic [47:0] P, PCOUT;
    logic        CARRYOUT, CARRYOUTF;

    int n_vec  = 0;
    int n_miss = 0;

    dsp u_dut (
        .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .BCIN(BCIN), .D(D), .C(C), .PCIN(PCIN),
        .OPMODE(OPMODE), .CARRYIN(CARRYIN),
        .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM), .RSTP(RSTP),
        .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
        .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
        .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF));

    always #5 CLK = ~CLK;

    task automatic check_vec(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_rst(input logic v);
        RSTA = v; RSTB = v; RSTC = v; RSTD = v; RSTM = v; RSTP = v;
        RSTCARRYIN = v; RSTOPMODE = v;
    endtask

    initial begin
        RST_N = 1'b0;
        A = '0; B = '0; BCIN = '0; D = '0; C = '0; PCIN = '0; OPMODE = '0; CARRYIN = 1'b0;
        set_rst(1'b1);
        CEA = 1; CEB = 1; CEC = 1; CED = 1; CEM = 1; CEP = 1; CECARRYIN = 1; CEOPMODE = 1;
        #12;
        RST_N = 1'b1;
        tick(1);

        // Sync clears held: outputs stay zero whatever the inputs do.
        for (int i = 0; i < 100; i++) begin
            A = 18'($urandom); B = 18'($urandom); D = 18'($urandom);
            C = {16'($urandom), 32'($urandom)}; OPMODE = 8'($urandom);
            CECARRYIN = 1'($urandom); CEOPMODE = 1'($urandom);
            tick(1);
            check_vec("rst_P", P, 48'h0);
            check_vec("rst_PCOUT", PCOUT, 48'h0);
            check_vec("rst_M", 48'(M), 48'h0);
            check_vec("rst_CO", 48'(CARRYOUT), 48'h0);
            check_vec("rst_COF", 48'(CARRYOUTF), 48'h0);
        end

        set_rst(1'b0);
        CECARRYIN = 1; CEOPMODE = 1;
        A = 18'h00123; B = 18'h00456; D = '0; C = '0; OPMODE = 8'h01;
        tick(3);
        check_vec("mul_M", 48'(M), 48'h4EDC2);
        check_vec("mul_P", P, 48'h4EDC2);
        check_vec("mul_BCOUT", 48'(BCOUT), 48'h456);

        A = 18'd2; B = 18'd5; D = 18'd10; OPMODE = 8'h11;
        tick(5);
        check_vec("preadd_M", 48'(M), 48'd30);
        check_vec("preadd_P", P, 48'd30);
        OPMODE = 8'h51;
        tick(5);
        check_vec("presub_M", 48'(M), 48'd10);
        check_vec("presub_P", P, 48'd10);

        C = 48'hFFFF_FFFF_FFFF; A = 0; D = 0; B = 18'd1; OPMODE = 8'h0F;
        tick(5);
        check_vec("cy_P", P, 48'h0);
        check_vec("cy_CO", 48'(CARRYOUT), 48'h1);
        check_vec("cy_COF", 48'(CARRYOUTF), 48'h1);

        C = 48'd100; B = 18'd7; OPMODE = 8'hAF;
        tick(5);
        check_vec("sub_P", P, 48'd92);
        check_vec("sub_CO", 48'(CARRYOUT), 48'h0);
        check_vec("sub_PCOUT", PCOUT, 48'd92);

        A = 18'd1; B = 18'd3; C = '0; OPMODE = 8'h09; RSTP = 1'b1;
        tick(4);
        check_vec("acc_clr_P", P, 48'h0);
        check_vec("acc_M", 48'(M), 48'd3);
        RSTP = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            check_vec("acc_P", P, 48'(3 * k));
        end
        CEP = 1'b0;
        tick(3);
        check_vec("acc_hold_P", P, 48'd12);
        CEP = 1'b1;
        tick(1);
        check_vec("acc_resume_P", P, 48'd15);
        RSTP = 1'b1;
        tick(1);
        check_vec("rstp_P", P, 48'h0);
        check_vec("rstp_M", 48'(M), 48'd3);
        RSTP = 1'b0;
        tick(1);
        check_vec("rstp_after_P", P, 48'd3);
        check_vec("acc_CO", 48'(CARRYOUT), 48'h0);

        #2;
        RST_N = 1'b0;
        #1;
        check_vec("async_P", P, 48'h0);
        check_vec("async_M", 48'(M), 48'h0);
        check_vec("async_BCOUT", 48'(BCOUT), 48'h0);
        RST_N = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
